ttl_74154_sync: RTL and testbench



---
 rtl/ttl_74154_sync_pkg.sv | 20 ++
 rtl/ttl_74154_decode_core.sv | 24 ++
 rtl/ttl_74154_sync.sv | 42 ++++
 tb/tb_ttl_74154_sync.sv | 115 +++++++++++
 4 files changed

// File: rtl/ttl_74154_sync_pkg.sv
// Shared constants and decode helper for the registered 74154-style decoder.
package ttl_74154_sync_pkg;

    localparam int unsigned MAX_OUT = 64;

    // Inactive (disabled / reset) output pattern; callers truncate to their width.
    localparam logic [MAX_OUT-1:0] ALL_ONES = '1;

    // One-hot-low pattern for addr; out-of-range addresses give all ones.
    function automatic logic [MAX_OUT-1:0] one_hot_low(input int unsigned addr,
                                                       input int unsigned width);
        logic [MAX_OUT-1:0] pattern;
        pattern = ALL_ONES;
        if (addr < width && addr < MAX_OUT) begin
            pattern = ~(MAX_OUT'(1) << addr);
        end
        return pattern;
    endfunction

endpackage

// File: rtl/ttl_74154_decode_core.sv
// Combinational enable gating and address decode producing the next output word.
module ttl_74154_decode_core
    import ttl_74154_sync_pkg::*;
#(
    parameter int unsigned WIDTH_OUT = 16,
    localparam int unsigned WIDTH_IN = $clog2(WIDTH_OUT)
) (
    input  logic                 enable1_bar,
    input  logic                 enable2_bar,
    input  logic [WIDTH_IN-1:0]  addr,
    output logic [WIDTH_OUT-1:0] next_y_c
);

    logic enabled;

    always_comb begin
        enabled  = ~enable1_bar & ~enable2_bar;
        next_y_c = WIDTH_OUT'(ALL_ONES);
        if (enabled) begin
            next_y_c = WIDTH_OUT'(one_hot_low(32'(addr), WIDTH_OUT));
        end
    end

endmodule

// File: rtl/ttl_74154_sync.sv
// Registered 4-to-16 (parameterised) active-low decoder/demultiplexer.
module ttl_74154_sync
    import ttl_74154_sync_pkg::*;
#(
    parameter int unsigned WIDTH_OUT  = 16,
    parameter int unsigned DELAY_RISE = 0,
    parameter int unsigned DELAY_FALL = 0,
    localparam int unsigned WIDTH_IN  = $clog2(WIDTH_OUT)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Enable1_bar,
    input  logic                 Enable2_bar,
    input  logic [WIDTH_IN-1:0]  A,
    output logic [WIDTH_OUT-1:0] Y
);

    logic [WIDTH_OUT-1:0] next_y_c;
    logic [WIDTH_OUT-1:0] y_q;

    ttl_74154_decode_core #(
        .WIDTH_OUT(WIDTH_OUT)
    ) u_decode_core (
        .enable1_bar(Enable1_bar),
        .enable2_bar(Enable2_bar),
        .addr       (A),
        .next_y_c   (next_y_c)
    );

    // Reset forces the inactive all-ones pattern without waiting for a clock.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            y_q <= WIDTH_OUT'(ALL_ONES);
        end else begin
            y_q <= next_y_c;
        end
    end

    // Simulation-only edge delays; zero by default so Y is the bare register.
    assign #(DELAY_RISE, DELAY_FALL) Y = y_q;

endmodule

// File: tb/tb_ttl_74154_sync.sv
// Directed self-checking bench for ttl_74154_sync at the default 16-output width.
module tb_ttl_74154_sync;

    logic        clk;
    logic        rst;
    logic        e1_bar;
    logic        e2_bar;
    logic [3:0]  a;
    logic [15:0] y;

    int n_vec;
    int n_err;

    ttl_74154_sync dut (
        .Clk        (clk),
        .Reset      (rst),
        .Enable1_bar(e1_bar),
        .Enable2_bar(e2_bar),
        .A          (a),
        .Y          (y)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] exp_y;
        n_vec  = 0;
        n_err  = 0;
        rst    = 1'b0;
        e1_bar = 1'b0;
        e2_bar = 1'b0;
        a      = 4'd0;
        step();
        step();

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1 check("reset_immediate", y, 16'hFFFF);
        step();
        check("reset_hold", y, 16'hFFFF);
        #2 rst = 1'b0;
        #1 check("reset_release_no_edge", y, 16'hFFFF);
        step();
        check("reset_release_edge", y, 16'hFFFE);

        // Enable gating at A=0
        e2_bar = 1'b1; step(); check("e2_high", y, 16'hFFFF);
        e1_bar = 1'b1; step(); check("both_high", y, 16'hFFFF);
        e2_bar = 1'b0; step(); check("e1_high", y, 16'hFFFF);
        a = 4'd1;      step(); check("e1_high_a1", y, 16'hFFFF);
        e1_bar = 1'b0; step(); check("enable_a1", y, 16'hFFFD);

        // Both enables transition together
        a = 4'd3; e1_bar = 1'b1; e2_bar = 1'b1;
        step(); check("a3_disabled", y, 16'hFFFF);
        e1_bar = 1'b0; e2_bar = 1'b0;
        #2 check("latency_no_comb", y, 16'hFFFF);
        step(); check("a3_enabled", y, 16'hFFF7);

        // Address sweep from MSB down to LSB
        a = 4'd15; step(); check("a15", y, 16'h7FFF);
        for (int k = 14; k >= 0; k--) begin
            a = 4'(k);
            exp_y = 16'hFFFF;
            exp_y[k] = 1'b0;
            step();
            check($sformatf("sweep_a%0d", k), y, exp_y);
        end

        // Disabled: address changes must not show
        e1_bar = 1'b1; e2_bar = 1'b1;
        step(); check("dis_a0", y, 16'hFFFF);
        a = 4'd5;  step(); check("dis_a5", y, 16'hFFFF);
        a = 4'd10; step(); check("dis_a10", y, 16'hFFFF);
        e1_bar = 1'b0; e2_bar = 1'b0; a = 4'd5;
        step(); check("en_a5", y, 16'hFFDF);
        a = 4'd10;
        #2 check("a10_before_edge", y, 16'hFFDF);
        step(); check("en_a10", y, 16'hFBFF);

        // Asynchronous reset mid-operation
        #2 rst = 1'b1;
        #1 check("midop_reset", y, 16'hFFFF);
        #1 rst = 1'b0;
        #1 check("midop_reset_released", y, 16'hFFFF);
        step(); check("midop_recover", y, 16'hFBFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
